// File: rtl/sequenciador_ula.sv
// sequenciador_ula: multi-cycle sequencer that drives the 16-bit ALU.
// Define SEQ_ULA_FLAGS_EN to build the Z/C/N/O flag logic.
module sequenciador_ula #(
    parameter int bits_palavra  = 16,
    parameter int bits_controle = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [15:0]              instrucao,
    input  logic                     instr_valida,
    output logic                     instr_pronta,
    input  logic                     carga_valida,
    input  logic [2:0]               carga_end,
    input  logic [bits_palavra-1:0]  carga_dado,
    input  logic [2:0]               end_leitura,
    output logic [bits_palavra-1:0]  dado_leitura,
    output logic [bits_controle-1:0] controle,
    output logic [bits_palavra-1:0]  operandoA,
    output logic [bits_palavra-1:0]  operandoB,
    input  logic [bits_palavra-1:0]  resultadoOp,
    output logic [3:0]               flags,
    output logic                     erro
);

    localparam int msb = bits_palavra - 1;
    localparam logic [bits_controle-1:0] ctrl_reset =
        {1'b1, {(bits_controle-1){1'b0}}};

    typedef enum logic [1:0] {
        OCIOSO,
        LEITURA,
        EXECUCAO,
        ESCRITA
    } estado_t;

    estado_t                  estado;
    logic [bits_controle-1:0] codigo;
    logic [2:0]               rd;
    logic [2:0]               ra;
    logic [2:0]               rb;
    logic [bits_palavra-1:0]  banco [8];
    logic [bits_palavra-1:0]  resultado;
    logic [1:0]               campo_unused;
    logic                     legal;

    assign campo_unused = instrucao[1:0];
    assign instr_pronta = (estado == OCIOSO);
    assign dado_leitura = banco[end_leitura];

    always_comb begin
        legal = 1'b0;
        case (codigo)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110,
            5'b01000, 5'b01001: legal = 1'b1;
            default:            legal = codigo[bits_controle-1];
        endcase
    end

`ifdef SEQ_ULA_FLAGS_EN
    logic [bits_palavra-1:0] b_ef;
    logic [bits_palavra-1:0] soma_unused;
    logic                    cin;
    logic                    carry;
    logic                    ovf;
    logic [3:0]              flags_calc;
    logic [3:0]              flags_prox;

    // Carry is rebuilt here; the ALU only returns the 16-bit result.
    always_comb begin
        b_ef        = operandoB;
        cin         = 1'b0;
        carry       = 1'b0;
        ovf         = 1'b0;
        soma_unused = '0;
        case (controle)
            5'b00000, 5'b00001, 5'b00011: begin
                if (controle == 5'b00011) b_ef = '0;
                cin = (controle != 5'b00000);
                {carry, soma_unused} = {1'b0, operandoA} + {1'b0, b_ef}
                                     + {{bits_palavra{1'b0}}, cin};
                ovf = (operandoA[msb] == b_ef[msb])
                   && (resultadoOp[msb] != operandoA[msb]);
            end
            5'b00100, 5'b00101, 5'b00110: begin
                if (controle == 5'b00110)
                    b_ef = {{(bits_palavra-1){1'b0}}, 1'b1};
                cin = (controle != 5'b00100);
                {carry, soma_unused} = {1'b0, operandoA} + {1'b0, ~b_ef}
                                     + {{bits_palavra{1'b0}}, cin};
                ovf = (operandoA[msb] != b_ef[msb])
                   && (resultadoOp[msb] != operandoA[msb]);
            end
            5'b01000: carry = operandoA[msb];
            5'b01001: carry = operandoA[0];
            default:  carry = 1'b0;
        endcase
        flags_calc = {resultadoOp == '0, carry, resultadoOp[msb], ovf};
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            codigo    <= '0;
            rd        <= '0;
            ra        <= '0;
            rb        <= '0;
            resultado <= '0;
            operandoA <= '0;
            operandoB <= '0;
            controle  <= ctrl_reset;
            erro      <= 1'b0;
            for (int i = 0; i < 8; i++) banco[i] <= '0;
`ifdef SEQ_ULA_FLAGS_EN
            flags      <= '0;
            flags_prox <= '0;
`endif
        end else begin
            erro <= 1'b0;
            if (carga_valida) banco[carga_end] <= carga_dado;
            unique case (estado)
                OCIOSO: begin
                    if (instr_valida) begin
                        codigo <= instrucao[15:11];
                        rd     <= instrucao[10:8];
                        ra     <= instrucao[7:5];
                        rb     <= instrucao[4:2];
                        estado <= LEITURA;
                    end
                end
                LEITURA: begin
                    operandoA <= banco[ra];
                    operandoB <= banco[rb];
                    controle  <= codigo;
                    estado    <= EXECUCAO;
                end
                EXECUCAO: begin
                    resultado <= resultadoOp;
                    erro      <= ~legal;
`ifdef SEQ_ULA_FLAGS_EN
                    flags_prox <= flags_calc;
`endif
                    estado    <= ESCRITA;
                end
                ESCRITA: begin
                    // Placed after the carga write so write-back wins.
                    if (legal) begin
                        banco[rd] <= resultado;
`ifdef SEQ_ULA_FLAGS_EN
                        flags <= flags_prox;
`endif
                    end
                    estado <= OCIOSO;
                end
            endcase
        end
    end

`ifndef SEQ_ULA_FLAGS_EN
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_sequenciador_ula.sv
// tb_sequenciador_ula: scoreboard bench with a bench-side ALU and
// an arithmetic reference model of the register file and flags.
module tb_sequenciador_ula;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instrucao = '0;
    logic        instr_valida = 1'b0;
    logic        instr_pronta;
    logic        carga_valida = 1'b0;
    logic [2:0]  carga_end = '0;
    logic [15:0] carga_dado = '0;
    logic [2:0]  end_leitura = '0;
    logic [15:0] dado_leitura;
    logic [4:0]  controle;
    logic [15:0] operandoA;
    logic [15:0] operandoB;
    logic [15:0] resultadoOp;
    logic [3:0]  flags;
    logic        erro;

`ifdef SEQ_ULA_FLAGS_EN
    localparam bit FL_EN = 1'b1;
`else
    localparam bit FL_EN = 1'b0;
`endif

    always #5 clock = ~clock;

    sequenciador_ula #(.bits_palavra(16), .bits_controle(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .instrucao    (instrucao),
        .instr_valida (instr_valida),
        .instr_pronta (instr_pronta),
        .carga_valida (carga_valida),
        .carga_end    (carga_end),
        .carga_dado   (carga_dado),
        .end_leitura  (end_leitura),
        .dado_leitura (dado_leitura),
        .controle     (controle),
        .operandoA    (operandoA),
        .operandoB    (operandoB),
        .resultadoOp  (resultadoOp),
        .flags        (flags),
        .erro         (erro)
    );

    function automatic logic [15:0] alu(input logic [4:0] c,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        logic [15:0] r;
        case (c)
            5'd0: r = a + b;
            5'd1: r = a + b + 16'd1;
            5'd3: r = a + 16'd1;
            5'd4: r = a - b - 16'd1;
            5'd5: r = a - b;
            5'd6: r = a - 16'd1;
            5'd8: r = {a[14:0], 1'b0};
            5'd9: r = {a[15], a[15:1]};
            default: begin
                if (c[4]) begin
                    case (c[2:0])
                        3'd0: r = a & b;
                        3'd1: r = a | b;
                        3'd2: r = a ^ b;
                        3'd3: r = ~a;
                        3'd4: r = b;
                        3'd5: r = a;
                        3'd6: r = 16'h0000;
                        default: r = {a[7:0], b[15:8]};
                    endcase
                    if (c[3]) r = ~r;
                end else begin
                    r = a ^ 16'hA5A5;
                end
            end
        endcase
        return r;
    endfunction

    always_comb resultadoOp = alu(controle, operandoA, operandoB);

    function automatic bit legal_mod(input logic [4:0] c);
        return (c inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9})
            || (c >= 5'd16);
    endfunction

    // Flags from integer arithmetic: carry/no-borrow and signed range.
    function automatic logic [3:0] flags_mod(input logic [4:0] c,
                                             input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [15:0] r);
        int ua, ub, sa, sb, ci, t, ts;
        bit cy, ov;
        cy = 1'b0;
        ov = 1'b0;
        ua = int'(a);
        sa = int'($signed(a));
        if (c inside {5'd0, 5'd1, 5'd3}) begin
            ub = (c == 5'd3) ? 0 : int'(b);
            sb = (c == 5'd3) ? 0 : int'($signed(b));
            ci = (c != 5'd0) ? 1 : 0;
            t  = ua + ub + ci;
            ts = sa + sb + ci;
            cy = (t > 65535);
            ov = (ts > 32767) || (ts < -32768);
        end else if (c inside {5'd4, 5'd5, 5'd6}) begin
            ub = (c == 5'd6) ? 1 : int'(b);
            sb = (c == 5'd6) ? 1 : int'($signed(b));
            ci = (c != 5'd4) ? 1 : 0;
            t  = ua - ub - (1 - ci);
            ts = sa - sb - (1 - ci);
            cy = (t >= 0);
            ov = (ts > 32767) || (ts < -32768);
        end else if (c == 5'd8) begin
            cy = a[15];
        end else if (c == 5'd9) begin
            cy = a[0];
        end
        return {r == 16'h0000, cy, r[15], ov};
    endfunction

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] valor;
        logic [3:0]  fl;
        bit          ilegal;
    } esp_t;

    esp_t        fila[$];
    logic [15:0] regs[8];
    logic [3:0]  fl_mod;
    int          checagens = 0;
    int          erros = 0;

    task automatic checa(input string nome, input logic [31:0] obtido,
                         input logic [31:0] esperado);
        checagens++;
        if (obtido !== esperado) begin
            erros++;
            $display("FAIL %s: obtido %0h esperado %0h", nome, obtido, esperado);
        end
    endtask

    task automatic zera_modelo();
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        fl_mod = 4'b0000;
    endtask

    task automatic carga(input logic [2:0] e, input logic [15:0] d,
                         input bit espera);
        @(negedge clock);
        if (espera) begin
            for (int n = 0; n < 20 && !instr_pronta; n++) @(negedge clock);
        end
        carga_valida = 1'b1;
        carga_end    = e;
        carga_dado   = d;
        @(posedge clock);
        #1;
        carga_valida = 1'b0;
        regs[e] = d;
    endtask

    task automatic executa(input logic [4:0] c, input logic [2:0] d,
                           input logic [2:0] a, input logic [2:0] b,
                           input bit mantem);
        esp_t        e;
        logic [15:0] va, vb, res;
        bit          ok;
        ok = 1'b0;
        instrucao    = {c, d, a, b, 2'b00};
        instr_valida = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (instr_pronta) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checa("aceite_timeout", 0, 1);
            instr_valida = 1'b0;
            return;
        end
        va  = regs[a];
        vb  = regs[b];
        res = alu(c, va, vb);
        e.rd     = d;
        e.ilegal = !legal_mod(c);
        if (!e.ilegal) begin
            regs[d] = res;
            if (FL_EN) fl_mod = flags_mod(c, va, vb, res);
        end
        e.valor = regs[d];
        e.fl    = fl_mod;
        fila.push_back(e);
        @(posedge clock);
        #1;
        if (!mantem) instr_valida = 1'b0;
    endtask

    function automatic logic [15:0] valor_canto();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: one comparison set per completed instruction.
    int   ocup = 0;
    int   nerro = 0;
    bit   ant = 1'b1;
    esp_t em;
    always @(negedge clock) begin
        bit p;
        p = instr_pronta;
        if (reset) begin
            ocup  = 0;
            nerro = 0;
            ant   = 1'b1;
        end else begin
            if (!p) begin
                ocup++;
                if (erro) nerro++;
            end else if (!ant) begin
                if (fila.size() == 0) begin
                    checa("fila_vazia", 0, 1);
                end else begin
                    em = fila.pop_front();
                    end_leitura = em.rd;
                    #1;
                    checa("registrador", dado_leitura, em.valor);
                    checa("flags", flags, em.fl);
                    checa("ciclos_ocupado", ocup, 3);
                    checa("pulsos_erro", nerro, em.ilegal);
                    checa("erro_ocioso", erro, 0);
                end
                ocup  = 0;
                nerro = 0;
            end
            ant = p;
        end
    end

    initial begin
        bit mant;
        zera_modelo();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checa("rst_pronta", instr_pronta, 1);
        checa("rst_controle", controle, 5'b10000);
        checa("rst_opA", operandoA, 0);
        checa("rst_opB", operandoB, 0);
        checa("rst_flags", flags, 0);
        checa("rst_erro", erro, 0);
        checa("rst_reg0", dado_leitura, 0);
        @(posedge clock);
        #1;

        carga(3'd1, 16'h7FFF, 1);
        carga(3'd2, 16'h0001, 1);
        executa(5'b00000, 3'd3, 3'd1, 3'd2, 0);
        carga(3'd1, 16'h0005, 1);
        carga(3'd2, 16'h0005, 1);
        executa(5'b00101, 3'd4, 3'd1, 3'd2, 0);
        executa(5'b00100, 3'd5, 3'd1, 3'd2, 0);
        carga(3'd1, 16'h8001, 1);
        executa(5'b01000, 3'd6, 3'd1, 3'd0, 0);
        executa(5'b01001, 3'd7, 3'd1, 3'd0, 0);
        executa(5'b00010, 3'd3, 3'd1, 3'd2, 0);

        executa(5'b00001, 3'd3, 3'd1, 3'd2, 1);
        executa(5'b00011, 3'd4, 3'd3, 3'd0, 1);
        executa(5'b00110, 3'd5, 3'd4, 3'd0, 1);
        executa(5'b10010, 3'd6, 3'd1, 3'd2, 0);

        // Operands come from the pre-edge register contents.
        executa(5'b00000, 3'd7, 3'd1, 3'd2, 0);
        carga(3'd1, 16'h1234, 0);

        carga(3'd1, 16'h1111, 1);
        carga(3'd2, 16'h2222, 1);
        executa(5'b00000, 3'd3, 3'd1, 3'd2, 0);
        repeat (3) @(negedge clock);
        carga_valida = 1'b1;
        carga_end    = 3'd3;
        carga_dado   = 16'hDEAD;
        @(posedge clock);
        #1 carga_valida = 1'b0;

        executa(5'b00000, 3'd2, 3'd1, 3'd1, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        fila.delete();
        @(posedge clock);
        #1;
        checa("abort_pronta", instr_pronta, 1);
        checa("abort_controle", controle, 5'b10000);
        checa("abort_opA", operandoA, 0);
        checa("abort_opB", operandoB, 0);
        checa("abort_flags", flags, 0);
        checa("abort_erro", erro, 0);
        zera_modelo();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checa("abort_pronta_apos", instr_pronta, 1);
        checa("abort_reg2", dado_leitura, 0);
        @(posedge clock);
        #1;
        executa(5'b00000, 3'd6, 3'd1, 3'd2, 0);

        mant = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (!mant) begin
                repeat ($urandom_range(0, 2))
                    carga(3'($urandom_range(0, 7)), valor_canto(), 1);
            end
            mant = (i < 149) && ($urandom_range(0, 3) == 0);
            executa(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    mant);
        end

        for (int n = 0; n < 50 && fila.size() != 0; n++) @(negedge clock);
        repeat (2) @(negedge clock);
        checa("fila_final", fila.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checagens, erros);
        $finish;
    end

endmodule

// File: doc/sequenciador_ula.md
# sequenciador_ula

Multi-cycle sequencer that drives the 16-bit ALU from the initiator side: accepts one encoded instruction over a valid/ready handshake, reads operands from an internal 8-entry register file, drives the ALU's 5-bit `controle` and operand inputs, captures `resultadoOp`, writes it back and updates the Z/C/N/O status flags that the ALU itself does not produce. It sits between instruction fetch and the combinational ALU in the datapath.

## Interface
Parameters:
- `bits_palavra`, 16, datapath width; ALU operand and result width.
- `bits_controle`, 5, ALU operation code width.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `instrucao`  in  16  [15:11] ALU code, [10:8] rd, [7:5] ra, [4:2] rb, [1:0] ignored.
- `instr_valida`  in  1  instruction offered.
- `instr_pronta`  out  1  sequencer idle; transfer when both high at an edge.
- `carga_valida`  in  1  external register-file write strobe.
- `carga_end`  in  3  external write address.
- `carga_dado`  in  16  external write data.
- `end_leitura`  in  3  debug read address.
- `dado_leitura`  out  16  combinational read of register `end_leitura`.
- `controle`  out  5  to ALU.
- `operandoA`, `operandoB`  out  16 each  to ALU (registered).
- `resultadoOp`  in  16  from ALU (combinational response).
- `flags`  out  4  {Z,C,N,O}, registered.
- `erro`  out  1  one-cycle pulse on illegal code.

## Operation
- FSM: OCIOSO → LEITURA → EXECUCAO → ESCRITA → OCIOSO. `instr_pronta` = (state == OCIOSO).
- OCIOSO: on `instr_valida && instr_pronta`, latch `instrucao`, go LEITURA.
- LEITURA: load `operandoA` ← R[ra], `operandoB` ← R[rb], `controle` ← code; go EXECUCAO.
- EXECUCAO: sample `resultadoOp` into internal result register; compute next flags; go ESCRITA.
- ESCRITA: if code legal, R[rd] ← result and `flags` updated; if illegal, no write, flags held, `erro`=1 this cycle only. Go OCIOSO.
- Legal codes: 00000, 00001, 00011, 00100, 00101, 00110, 01000, 01001, 10000–11111. All others illegal.
- Flags: Z = (result == 0); N = result[15].
  - Add codes (00000/00001/00011): C = bit 16 of unsigned 17-bit A+B+cin (B=0,cin=1 for 00011); O = A[15]==B'[15] && result[15]!=A[15].
  - Sub codes (00100/00101/00110): C = carry out of A + ~B' + cin (1 = no borrow; cin=0 for 00100, 1 for 00101; 00110 uses B'=1, cin=1); O = A[15]!=B'[15] && result[15]!=A[15].
  - 01000: C = A[15]; 01001: C = A[0]; O = 0 for both.
  - Logic/constant codes (1xxxx): C = 0, O = 0.
- `carga_valida` writes R[carga_end] ← `carga_dado` in any state. Same-edge collision with ESCRITA on same address: ESCRITA wins.
- `controle`, `operandoA`, `operandoB` hold their last values outside LEITURA.

## Timing
- Reset values: state OCIOSO, all registers 0, `operandoA`/`operandoB` = 0, `controle` = 10000, `flags` = 0000, `erro` = 0; `instr_pronta` = 1 from the first cycle after reset.
- Handshake accepted at edge 0 → operands driven after edge 1 → result captured at edge 2 → R[rd] and `flags` visible after edge 3; `instr_pronta` high again after edge 3. Throughput: one instruction per 4 cycles.
- `instr_valida` while not ready: ignored, no queueing.
- LEITURA reads register contents as of that edge; a `carga` on the same edge is not seen.
- Reset mid-operation: instruction aborted, no write-back, no `erro`, all state returns to reset values.

## Configuration
- `SEQ_ULA_FLAGS_EN` defined: flag computation and `flags` register as above.
- Undefined: flag logic absent, `flags` tied to 0000; all other behaviour unchanged, including `erro`.

## Test plan
- Load R1=0x7FFF, R2=0x0001; instr 00000 rd=3 ra=1 rb=2 → R3=0x8000, flags Z0 C0 N1 O1, 4 cycles after acceptance.
- R1=R2=0x0005; 00101 rd=4 → R4=0x0000, flags Z1 C1 N0 O0; 00100 rd=5 → R5=0xFFFF, Z0 C0 N1 O0.
- R1=0x8001; 01000 → 0x0002, C1 N0; 01001 → 0xC000, C1 N1.
- Code 00010 → `erro` pulses exactly one cycle in ESCRITA, R[rd] and `flags` unchanged; `instr_valida` held high during busy → only one instruction accepted per 4 cycles.
- `carga` to R3 on the same edge as ESCRITA to R3 → ESCRITA value remains; `reset` asserted in EXECUCAO → no write, all outputs at reset values, `instr_pronta`=1 next cycle.
